serial_subtractor: RTL

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_arith_pkg.sv | 14 +
 rtl/full_subtractor.sv | 16 +
 rtl/serial_subtractor.sv | 100 ++++++++++
 3 files changed

// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks.
package serial_arith_pkg;

    // Operand width used when the instantiating parent does not override it.
    localparam int DEFAULT_WIDTH = 8;

    // Control states of the serial subtractor.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: D = A - B - Bin, with borrow-out.
module full_subtractor (
    input  logic A,
    input  logic B,
    input  logic Bin,
    output logic D,
    output logic Bout
);

    // Pure combinational cell; the borrow chain is closed through a flop in the parent.
    always_comb begin
        D    = A ^ B ^ Bin;
        Bout = (~A & B) | (~(A ^ B) & Bin);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b one bit per clock, LSB first.
// A start accepted at edge k produces a one-cycle done pulse after edge k+WIDTH.
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             ovf
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] diff_sr;
    logic             brw;
    logic [CW-1:0]    cnt;
    logic             a_msb;
    logic             b_msb;
    logic             d_bit;
    logic             b_out;
    logic             accept;

    // Start is only honoured when no operation is in flight.
    assign accept = start && (state != SHIFT);

    full_subtractor u_cell (
        .A   (a_sr[0]),
        .B   (b_sr[0]),
        .Bin (brw),
        .D   (d_bit),
        .Bout(b_out)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Next-state logic; DONE chains straight into SHIFT when start is held.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = SHIFT;
            SHIFT:   if (cnt == LAST) next_state = DONE;
            DONE:    next_state = start ? SHIFT : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Datapath: load operands on accept, then one subtract-and-shift per SHIFT cycle.
    // Operand MSBs are kept aside because the shift registers drain during SHIFT.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr    <= '0;
            b_sr    <= '0;
            diff_sr <= '0;
            brw     <= 1'b0;
            cnt     <= '0;
            a_msb   <= 1'b0;
            b_msb   <= 1'b0;
        end else if (accept) begin
            a_sr  <= a;
            b_sr  <= b;
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
            brw   <= 1'b0;
            cnt   <= '0;
        end else if (state == SHIFT) begin
            a_sr    <= a_sr >> 1;
            b_sr    <= b_sr >> 1;
            diff_sr <= {d_bit, diff_sr[WIDTH-1:1]};
            brw     <= b_out;
            cnt     <= cnt + CW'(1);
        end
    end

    // Outputs come only from registers, so there is no path from start/a/b.
    always_comb begin
        busy   = (state == SHIFT);
        done   = (state == DONE);
        diff   = diff_sr;
        borrow = brw;
        ovf    = (a_msb != b_msb) && (diff_sr[WIDTH-1] != a_msb);
    end

endmodule
